// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store controller.
//   Opcode and funct3 constants for the supported RV32 load/store forms,
//   the controller state enum, and small decode helpers used by lsu_ctrl.
//   No ports (package).
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // True for the eight load/store forms the controller implements.
  function automatic logic lsu_supported(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OP_LOAD)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    else if (op == OP_STORE)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return ok;
  endfunction

  // Access size is encoded in funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte offset actually used: halfwords drop bit 0, words use offset 0.
  // For naturally aligned accesses this is the address offset unchanged.
  function automatic logic [1:0] lsu_eff_off(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] eff;
    case (f3[1:0])
      2'b01:   eff = {off[1], 1'b0};
      2'b10:   eff = 2'b00;
      default: eff = off;
    endcase
    return eff;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align -- combinational load data alignment.
//   Shifts the captured memory word down by the byte offset and sign- or
//   zero-extends it according to funct3 (lb/lh/lw/lbu/lhu).
// Ports:
//   i_word   captured full memory word
//   i_funct3 load funct3
//   i_off    effective byte offset within the word
//   o_data   extended load result (0 for non-load funct3)
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_off,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;

  assign w_shifted = i_word >> {i_off, 3'b000};

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_B:    o_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_data = w_shifted;
      F3_BU:   o_data = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
      F3_HU:   o_data = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- multi-cycle load/store controller between execute and data memory.
//   Accepts one load/store per req handshake, builds the word-aligned memory
//   request (store lane replication + byte mask), waits for the memory
//   response and returns extended load data on the resp channel.
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned lh/lhu/sh/lw/sw return resp_err with no memory access
//   undefined -> offending low address bits are cleared and the access proceeds
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_inst/req_addr/req_wdata   execute-side request
//   resp_valid/resp_ready/resp_rdata/resp_err         writeback-side response
//   mem_req_valid/mem_req_ready/mem_addr/mem_wen/
//   mem_wdata/mem_wmask                                memory request
//   mem_rsp_valid/mem_rdata                            memory response
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_inst,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  lsu_state_e          r_state;
  logic [2:0]          r_funct3;
  logic                r_is_load;
  logic                r_err;
  logic                r_wen;
  logic [1:0]          r_off;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_wmask;
  logic [DATA_W-1:0]   r_word;

  logic [6:0]          w_op;
  logic [2:0]          w_f3;
  logic                w_supported;
  logic                w_err;
  logic                w_is_load;
  logic                w_is_store;
  logic [1:0]          w_off;
  logic [MASK_W-1:0]   w_wmask;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_load_data;
  logic                w_unused;

  // Instruction bits outside opcode/funct3 carry no meaning here.
  assign w_unused = &{1'b0, req_inst[31:15], req_inst[11:7]};

  assign w_op        = req_inst[6:0];
  assign w_f3        = req_inst[14:12];
  assign w_supported = lsu_supported(w_op, w_f3);
  assign w_is_load   = (w_op == OP_LOAD) && w_supported;
  assign w_is_store  = (w_op == OP_STORE) && w_supported;
  assign w_off       = lsu_eff_off(w_f3, req_addr[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = lsu_misaligned(w_f3, req_addr[1:0]);
  assign w_err        = !w_supported || w_misaligned;
`else
  assign w_err        = !w_supported;
`endif

  // Store lanes: narrow data is replicated across the word so the mask alone
  // selects which bytes memory writes.
  always_comb begin
    w_wmask = '0;
    w_wdata = '0;
    if (w_is_store) begin
      case (w_f3)
        F3_B: begin
          w_wmask = MASK_W'(1) << w_off;
          w_wdata = {(DATA_W/8){req_wdata[7:0]}};
        end
        F3_H: begin
          w_wmask = MASK_W'(3) << w_off;
          w_wdata = {(DATA_W/16){req_wdata[15:0]}};
        end
        default: begin
          w_wmask = '1;
          w_wdata = req_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_funct3  <= '0;
      r_is_load <= 1'b0;
      r_err     <= 1'b0;
      r_wen     <= 1'b0;
      r_off     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_word    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_funct3  <= w_f3;
            r_is_load <= w_is_load && !w_err;
            r_err     <= w_err;
            r_wen     <= w_is_store && !w_err;
            r_off     <= w_off;
            r_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
            r_wdata   <= w_err ? '0 : w_wdata;
            r_wmask   <= w_err ? '0 : w_wmask;
            // Clear the previous word so resp_rdata reads 0 until new data lands.
            r_word    <= '0;
            r_state   <= w_err ? RESP : REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          // Only here is a memory response meaningful; elsewhere it is dropped.
          if (mem_rsp_valid) begin
            r_word  <= mem_rdata;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  lsu_load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .i_word  (r_word),
    .i_funct3(r_funct3),
    .i_off   (r_off),
    .o_data  (w_load_data)
  );

  assign req_ready     = (r_state == IDLE);
  assign mem_req_valid = (r_state == REQ);
  assign resp_valid    = (r_state == RESP);
  assign resp_err      = (r_state == RESP) && r_err;
  assign resp_rdata    = r_is_load ? w_load_data : '0;
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
//   Directed cases followed by randomized transactions; expected values come
//   from a byte-level reference model of the load/store rules.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_inst, req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;

  int errors = 0;
  int checks = 0;

  // reference model outputs
  logic        e_err, e_wen;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_mask;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_inst     (req_inst),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] v;
    v = $urandom;
    v[6:0]   = op;
    v[14:12] = f3;
    return v;
  endfunction

  // Byte-level model: size/sign from funct3, lanes chosen by offset, stores
  // replicate the low bytes cyclically, loads take a byte range and extend.
  task automatic model(input logic [31:0] inst, addr, wdata, rdata);
    int     op, f3, nbytes, off;
    bit     ld, st, sgn, ok, mis;
    longint val;
    op = int'(inst[6:0]);
    f3 = int'(inst[14:12]);
    ld = (op == 3);
    st = (op == 35);
    ok = 0; nbytes = 0; sgn = 0;
    if (ld) begin
      case (f3)
        0: begin ok = 1; nbytes = 1; sgn = 1; end
        1: begin ok = 1; nbytes = 2; sgn = 1; end
        2: begin ok = 1; nbytes = 4; end
        4: begin ok = 1; nbytes = 1; end
        5: begin ok = 1; nbytes = 2; end
        default: ok = 0;
      endcase
    end else if (st) begin
      case (f3)
        0: begin ok = 1; nbytes = 1; end
        1: begin ok = 1; nbytes = 2; end
        2: begin ok = 1; nbytes = 4; end
        default: ok = 0;
      endcase
    end
    off = int'(addr % 4);
    mis = (nbytes != 0) && ((off % nbytes) != 0);
    if (mis) off = off - (off % nbytes);
`ifdef LSU_MISALIGN_TRAP_EN
    e_err = !ok || mis;
`else
    e_err = !ok;
`endif
    e_addr  = addr & ~32'h3;
    e_wen   = st && ok && !e_err;
    e_mask  = '0;
    e_wdata = '0;
    if (e_wen) begin
      for (int j = 0; j < 4; j++) begin
        if (j >= off && j < off + nbytes) e_mask[j] = 1'b1;
        e_wdata[8*j +: 8] = wdata[8*(j % nbytes) +: 8];
      end
    end
    e_rdata = '0;
    if (ld && ok && !e_err) begin
      val = longint'(rdata);
      val = (val >> (8 * off)) & ((64'd1 << (8 * nbytes)) - 1);
      if (sgn && val >= longint'(64'd1 << (8 * nbytes - 1))) val = val - longint'(64'd1 << (8 * nbytes));
      e_rdata = val[31:0];
    end
  endtask

  // One full transaction: accept, memory request with rdy_dly stall cycles,
  // memory response after rsp_dly idle cycles, writeback stalled ack_dly cycles.
  task automatic txn(input string name, input logic [31:0] inst, addr, wdata, rdata,
                     input int rdy_dly, input int rsp_dly, input int ack_dly);
    model(inst, addr, wdata, rdata);
    chk({name, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_inst = inst; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Scramble request inputs: the controller must hold its latched copy.
    req_valid = 1'b0; req_inst = $urandom; req_addr = $urandom; req_wdata = $urandom;
    if (!e_err) begin
      for (int k = 0; k <= rdy_dly; k++) begin
        chk({name, " mem_req_valid"}, 32'(mem_req_valid), 32'd1);
        chk({name, " mem_addr"}, mem_addr, e_addr);
        chk({name, " mem_wmask"}, 32'(mem_wmask), 32'(e_mask));
        chk({name, " mem_wen"}, 32'(mem_wen), 32'(e_wen));
        if (e_wen) chk({name, " mem_wdata"}, mem_wdata, e_wdata);
        chk({name, " req_ready_busy"}, 32'(req_ready), 32'd0);
        chk({name, " resp_valid_req"}, 32'(resp_valid), 32'd0);
        if (k == rdy_dly) mem_req_ready = 1'b1;
        else if (k == 0) begin
          // stray response while still in the request phase must be ignored
          mem_rsp_valid = 1'b1; mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      end
      for (int k = 0; k <= rsp_dly; k++) begin
        chk({name, " mem_req_valid_wait"}, 32'(mem_req_valid), 32'd0);
        chk({name, " mem_addr_wait"}, mem_addr, e_addr);
        chk({name, " resp_valid_wait"}, 32'(resp_valid), 32'd0);
        if (k == rsp_dly) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      end
    end
    for (int k = 0; k <= ack_dly; k++) begin
      chk({name, " resp_valid"}, 32'(resp_valid), 32'd1);
      chk({name, " resp_err"}, 32'(resp_err), 32'(e_err));
      chk({name, " resp_rdata"}, resp_rdata, e_rdata);
      chk({name, " req_ready_resp"}, 32'(req_ready), 32'd0);
      chk({name, " mem_req_valid_resp"}, 32'(mem_req_valid), 32'd0);
      resp_ready = (k == ack_dly);
      @(negedge clk);
      resp_ready = 1'b0;
    end
    chk({name, " resp_valid_done"}, 32'(resp_valid), 32'd0);
    chk({name, " req_ready_done"}, 32'(req_ready), 32'd1);
    $display("txn %s inst=%h addr=%h err=%0d rdata=%h", name, inst, addr, e_err, e_rdata);
  endtask

  initial begin
    logic [31:0] inst;
    int          idx;
    rst = 1'b1;
    req_valid = 1'b0; req_inst = '0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst mem_wen", 32'(mem_wen), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);

    // directed cases
    txn("lb_neg", mk(7'h03, 3'b000), 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
    txn("lhu_zw", mk(7'h03, 3'b101), 32'h8000_0002, 32'h0, 32'h8001_0000, 0, 0, 0);
    txn("sh_hi", mk(7'h23, 3'b001), 32'h8000_0002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 0, 0);
    txn("lw_mis", mk(7'h03, 3'b010), 32'h8000_0001, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
    txn("sw_mis", mk(7'h23, 3'b010), 32'h8000_0003, 32'h5566_7788, 32'h0, 1, 0, 0);
    txn("lh_odd", mk(7'h03, 3'b001), 32'h8000_0001, 32'h0, 32'h1234_F678, 0, 1, 0);
    txn("sb_lane1", mk(7'h23, 3'b000), 32'h8000_0005, 32'hFFFF_FF5A, 32'h0, 0, 0, 1);
    txn("unsup_op", mk(7'h33, 3'b000), 32'h8000_0000, 32'h0, 32'h1111_1111, 0, 0, 0);
    txn("unsup_ld_f3", mk(7'h03, 3'b011), 32'h8000_0000, 32'h0, 32'h2222_2222, 0, 0, 2);
    txn("stall_lw", mk(7'h03, 3'b010), 32'h8000_0104, 32'h0, 32'h8765_4321, 5, 3, 2);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 8);
      case (idx)
        0: inst = mk(7'h03, 3'b000);
        1: inst = mk(7'h03, 3'b001);
        2: inst = mk(7'h03, 3'b010);
        3: inst = mk(7'h03, 3'b100);
        4: inst = mk(7'h03, 3'b101);
        5: inst = mk(7'h23, 3'b000);
        6: inst = mk(7'h23, 3'b001);
        7: inst = mk(7'h23, 3'b010);
        default: inst = $urandom;
      endcase
      txn($sformatf("rnd%0d", n), inst, $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // reset while waiting for memory, then a stray late response
    req_valid = 1'b1; req_inst = mk(7'h03, 3'b010); req_addr = 32'h8000_0010; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rstwait in_wait", 32'(mem_req_valid), 32'd0);
    chk("rstwait addr_before", mem_addr, 32'h8000_0010);
    rst = 1'b1;
    #1;
    chk("rstwait resp_valid", 32'(resp_valid), 32'd0);
    chk("rstwait mem_addr", mem_addr, 32'd0);
    chk("rstwait mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rstwait req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("stray resp_valid", 32'(resp_valid), 32'd0);
    chk("stray req_ready", 32'(req_ready), 32'd1);
    chk("stray resp_rdata", resp_rdata, 32'd0);
    $display("txn rst_in_wait addr=80000010 aborted");
    txn("post_rst_lbu", mk(7'h03, 3'b100), 32'h8000_0001, 32'h0, 32'h0000_9A00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
